// File: rtl/comb_seq_pkg.sv
// Shared definitions for the 5-layer to 4-layer combination sequencer:
// mux select encodings, sequencer state encoding and a saturating counter helper.
package comb_seq_pkg;

  localparam int NUM_LAYERS = 5;

  // Mux select: SEL_FULL passes the whole word, SEL_DROPk removes layer k
  localparam logic [2:0] SEL_FULL  = 3'b000;
  localparam logic [2:0] SEL_DROP0 = 3'b001;
  localparam logic [2:0] SEL_DROP1 = 3'b010;
  localparam logic [2:0] SEL_DROP2 = 3'b011;
  localparam logic [2:0] SEL_DROP3 = 3'b100;
  localparam logic [2:0] SEL_DROP4 = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/comb_seq_plan.sv
// Beat plan for one latched combination: first mux select, number of beats,
// and whether the word is discarded.
module comb_seq_plan
  import comb_seq_pkg::*;
(
  input  logic [NUM_LAYERS-1:0] hitmask,
  input  logic                  is_45,
  output logic [2:0]            first_sel,
  output logic [2:0]            num_beats,
  output logic                  drop
);

  // Map hit mask and mode onto the select walk
  always_comb begin
    first_sel = SEL_FULL;
    num_beats = 3'd0;
    drop      = 1'b1;
    if (!is_45) begin
      if (hitmask == 5'b11111) begin
        first_sel = SEL_FULL;
        num_beats = 3'd1;
        drop      = 1'b0;
      end else begin
        drop      = 1'b1;
      end
    end else begin
      // exactly one missing layer selects the variant that drops it
      case (hitmask)
        5'b11111: begin first_sel = SEL_DROP0; num_beats = 3'd5; drop = 1'b0; end
        5'b11110: begin first_sel = SEL_DROP0; num_beats = 3'd1; drop = 1'b0; end
        5'b11101: begin first_sel = SEL_DROP1; num_beats = 3'd1; drop = 1'b0; end
        5'b11011: begin first_sel = SEL_DROP2; num_beats = 3'd1; drop = 1'b0; end
        5'b10111: begin first_sel = SEL_DROP3; num_beats = 3'd1; drop = 1'b0; end
        5'b01111: begin first_sel = SEL_DROP4; num_beats = 3'd1; drop = 1'b0; end
        default:  begin first_sel = SEL_FULL;  num_beats = 3'd0; drop = 1'b1; end
      endcase
    end
  end

endmodule

// File: rtl/comb_seq_55_to_45.sv
// Sequencer driving the 5-to-4 layer hit combination mux select, one beat per cycle.
// Optional statistics counters are built when COMB_SEQ_STATS_EN is defined.
module comb_seq_55_to_45
  import comb_seq_pkg::*;
#(
  parameter int COMB_W = 111,
  parameter int ZETA_W = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [COMB_W-1:0]     in_comb,
  input  logic [ZETA_W-1:0]     in_zeta,
  input  logic [NUM_LAYERS-1:0] in_hitmask,
  input  logic                  in_last,
  input  logic                  in_ee,
  input  logic                  in_xftlast,
  input  logic                  is_45,
  output logic [COMB_W-1:0]     mux_comb,
  output logic [ZETA_W-1:0]     mux_zeta,
  output logic [2:0]            mux_sel,
  output logic                  mux_is_45,
  output logic                  mux_last,
  output logic                  mux_ee,
  output logic                  mux_xftlast,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  drop_pulse
`ifdef COMB_SEQ_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [31:0]           beats_out,
  output logic [31:0]           words_in,
  output logic [31:0]           words_dropped
`endif
);

  state_t              state_r, state_s;
  logic [2:0]          sel_r, sel_s;
  logic [2:0]          remain_r, remain_s;
  logic [COMB_W-1:0]   comb_r, comb_s;
  logic [ZETA_W-1:0]   zeta_r, zeta_s;
  logic                is45_r, is45_s;
  logic                last_r, last_s;
  logic                ee_r, ee_s;
  logic                xft_r, xft_s;
  logic                mux_last_r, mux_last_s;
  logic                mux_ee_r, mux_ee_s;
  logic                valid_r, valid_s;
  logic                drop_r, drop_s;
  logic [2:0]          plan_sel_s;
  logic [2:0]          plan_beats_s;
  logic                plan_drop_s;
  logic                plan_final_s;
  logic                accept_s;
  logic                fire_s;
  logic                load_s;

  comb_seq_plan u_plan (
    .hitmask   (in_hitmask),
    .is_45     (is_45),
    .first_sel (plan_sel_s),
    .num_beats (plan_beats_s),
    .drop      (plan_drop_s)
  );

  // Ready also covers the final beat leaving, so words chain without a bubble
  assign in_ready = !reset && ((state_r == IDLE) ||
                               ((state_r == EMIT) && (remain_r == 3'd0) && out_ready));
  assign accept_s     = in_valid && in_ready;
  assign fire_s       = valid_r && out_ready;
  assign plan_final_s = (plan_beats_s == 3'd1);

  // Next-state and next-output logic for the beat walk
  always_comb begin
    state_s    = state_r;
    sel_s      = sel_r;
    remain_s   = remain_r;
    comb_s     = comb_r;
    zeta_s     = zeta_r;
    is45_s     = is45_r;
    last_s     = last_r;
    ee_s       = ee_r;
    xft_s      = xft_r;
    mux_last_s = mux_last_r;
    mux_ee_s   = mux_ee_r;
    valid_s    = valid_r;
    drop_s     = 1'b0;
    load_s     = 1'b0;
    case (state_r)
      IDLE: begin
        load_s = accept_s;
      end
      EMIT: begin
        if (fire_s && (remain_r == 3'd0)) begin
          load_s     = accept_s;
          state_s    = IDLE;
          valid_s    = 1'b0;
          sel_s      = SEL_FULL;
          mux_last_s = 1'b0;
          mux_ee_s   = 1'b0;
        end else if (fire_s) begin
          sel_s      = sel_r + 3'd1;
          remain_s   = remain_r - 3'd1;
          mux_last_s = last_r && (remain_r == 3'd1);
          mux_ee_s   = ee_r && (remain_r == 3'd1);
        end else begin
          state_s    = EMIT;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
        sel_s   = SEL_FULL;
      end
    endcase

    if (load_s) begin
      comb_s = in_comb;
      zeta_s = in_zeta;
      is45_s = is_45;
      last_s = in_last;
      ee_s   = in_ee;
      xft_s  = in_xftlast;
      drop_s = plan_drop_s;
      // a discarded road/event closer still emits one terminal full-select beat
      if (plan_drop_s && in_last) begin
        state_s    = EMIT;
        valid_s    = 1'b1;
        sel_s      = SEL_FULL;
        remain_s   = 3'd0;
        mux_last_s = 1'b1;
        mux_ee_s   = in_ee;
      end else if (plan_drop_s) begin
        state_s    = IDLE;
        valid_s    = 1'b0;
        sel_s      = SEL_FULL;
        remain_s   = 3'd0;
        mux_last_s = 1'b0;
        mux_ee_s   = 1'b0;
      end else begin
        state_s    = EMIT;
        valid_s    = 1'b1;
        sel_s      = plan_sel_s;
        remain_s   = plan_beats_s - 3'd1;
        mux_last_s = in_last && plan_final_s;
        mux_ee_s   = in_ee && plan_final_s;
      end
    end else begin
      drop_s = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      sel_r      <= SEL_FULL;
      remain_r   <= 3'd0;
      comb_r     <= '0;
      zeta_r     <= '0;
      is45_r     <= 1'b0;
      last_r     <= 1'b0;
      ee_r       <= 1'b0;
      xft_r      <= 1'b0;
      mux_last_r <= 1'b0;
      mux_ee_r   <= 1'b0;
      valid_r    <= 1'b0;
      drop_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      sel_r      <= sel_s;
      remain_r   <= remain_s;
      comb_r     <= comb_s;
      zeta_r     <= zeta_s;
      is45_r     <= is45_s;
      last_r     <= last_s;
      ee_r       <= ee_s;
      xft_r      <= xft_s;
      mux_last_r <= mux_last_s;
      mux_ee_r   <= mux_ee_s;
      valid_r    <= valid_s;
      drop_r     <= drop_s;
    end
  end

  assign mux_comb    = comb_r;
  assign mux_zeta    = zeta_r;
  assign mux_sel     = sel_r;
  assign mux_is_45   = is45_r;
  assign mux_last    = mux_last_r;
  assign mux_ee      = mux_ee_r;
  assign mux_xftlast = xft_r;
  assign out_valid   = valid_r;
  assign drop_pulse  = drop_r;

`ifdef COMB_SEQ_STATS_EN
  logic [31:0] beats_r;
  logic [31:0] words_in_r;
  logic [31:0] dropped_r;

  // Saturating activity counters
  always_ff @(posedge clk) begin
    if (reset || stats_clr) begin
      beats_r    <= 32'd0;
      words_in_r <= 32'd0;
      dropped_r  <= 32'd0;
    end else begin
      if (fire_s) begin
        beats_r <= sat_inc(beats_r);
      end
      if (accept_s) begin
        words_in_r <= sat_inc(words_in_r);
      end
      if (accept_s && plan_drop_s) begin
        dropped_r <= sat_inc(dropped_r);
      end
    end
  end

  assign beats_out     = beats_r;
  assign words_in      = words_in_r;
  assign words_dropped = dropped_r;
`endif

endmodule

// File: tb/tb_comb_seq_55_to_45.sv
// Directed scoreboard bench for comb_seq_55_to_45: expected beats are queued at
// accept and compared as the sequencer hands them downstream.
module tb_comb_seq_55_to_45;
  import comb_seq_pkg::*;

  localparam int CW = 111;
  localparam int ZW = 12;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [CW-1:0]  in_comb = '0;
  logic [ZW-1:0]  in_zeta = '0;
  logic [4:0]     in_hitmask = 5'b00000;
  logic           in_last = 1'b0;
  logic           in_ee = 1'b0;
  logic           in_xftlast = 1'b0;
  logic           is_45 = 1'b0;
  logic [CW-1:0]  mux_comb;
  logic [ZW-1:0]  mux_zeta;
  logic [2:0]     mux_sel;
  logic           mux_is_45;
  logic           mux_last;
  logic           mux_ee;
  logic           mux_xftlast;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           drop_pulse;

  always #5 clk = ~clk;

  comb_seq_55_to_45 #(.COMB_W(CW), .ZETA_W(ZW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_comb(in_comb), .in_zeta(in_zeta), .in_hitmask(in_hitmask),
    .in_last(in_last), .in_ee(in_ee), .in_xftlast(in_xftlast), .is_45(is_45),
    .mux_comb(mux_comb), .mux_zeta(mux_zeta), .mux_sel(mux_sel),
    .mux_is_45(mux_is_45), .mux_last(mux_last), .mux_ee(mux_ee),
    .mux_xftlast(mux_xftlast), .out_valid(out_valid), .out_ready(out_ready),
    .drop_pulse(drop_pulse)
  );

  typedef struct {
    logic [2:0]    sel;
    logic [CW-1:0] comb;
    logic [ZW-1:0] zeta;
    logic          last;
    logic          ee;
    logic          xft;
    logic          i45;
    logic          fin;
  } beat_t;

  beat_t q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    exp_drop = 0;   // 0: expect no pulse, 1: expect pulse, 2: not checked
  logic  vld_seen = 1'b0;
  logic  rdy_seen = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, return just after the rising edge
  task automatic step();
    beat_t b;
    @(negedge clk);
    vld_seen = out_valid;
    rdy_seen = in_ready;
    if (reset) begin
      chk("ready_in_reset", 128'(in_ready), 128'(1'b0));
      exp_drop = 0;
    end else begin
      chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
      if (exp_drop != 2) chk("drop_pulse", 128'(drop_pulse), 128'(exp_drop == 1));
      exp_drop = 0;
      if (out_valid && (q.size() != 0)) begin
        b = q[0];
        chk("in_ready_emit", 128'(in_ready), 128'(b.fin && out_ready));
        chk("mux_sel", 128'(mux_sel), 128'(b.sel));
        chk("mux_comb", 128'(mux_comb), 128'(b.comb));
        if (out_ready) begin
          chk("mux_zeta", 128'(mux_zeta), 128'(b.zeta));
          chk("mux_last", 128'(mux_last), 128'(b.last));
          chk("mux_ee", 128'(mux_ee), 128'(b.ee));
          chk("mux_xftlast", 128'(mux_xftlast), 128'(b.xft));
          chk("mux_is_45", 128'(mux_is_45), 128'(b.i45));
          void'(q.pop_front());
        end
      end else begin
        chk("in_ready_idle", 128'(in_ready), 128'(1'b1));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [2:0] s, input logic [CW-1:0] c, input logic [ZW-1:0] z,
                           input logic l, input logic e, input logic x, input logic i45,
                           input logic fin);
    beat_t b;
    b.sel = s; b.comb = c; b.zeta = z; b.last = l && fin; b.ee = e && fin;
    b.xft = x; b.i45 = i45; b.fin = fin;
    q.push_back(b);
  endtask

  // Reference beat plan written from the mux's point of view
  task automatic model(input logic [CW-1:0] c, input logic [ZW-1:0] z, input logic [4:0] m,
                       input logic l, input logic e, input logic x, input logic i45);
    int zeros;
    int hole;
    zeros = 0;
    hole  = 0;
    for (int k = 0; k < 5; k++) begin
      if (!m[k]) begin
        zeros++;
        hole = k;
      end
    end
    if (!i45 && zeros == 0) begin
      push_beat(3'd0, c, z, l, e, x, i45, 1'b1);
    end else if (i45 && zeros == 0) begin
      for (int k = 1; k <= 5; k++) push_beat(3'(k), c, z, l, e, x, i45, k == 5);
    end else if (i45 && zeros == 1) begin
      push_beat(3'(hole + 1), c, z, l, e, x, i45, 1'b1);
    end else if (l) begin
      push_beat(3'd0, c, z, 1'b1, e, x, i45, 1'b1);
      exp_drop = 2;
    end else begin
      exp_drop = 1;
    end
  endtask

  task automatic send(input logic [CW-1:0] c, input logic [4:0] m, input logic l,
                      input logic e, input logic x, input logic i45);
    int t;
    in_comb = c; in_zeta = c[ZW-1:0] ^ 12'hA5A; in_hitmask = m;
    in_last = l; in_ee = e; in_xftlast = x; is_45 = i45; in_valid = 1'b1;
    t = 0;
    do begin
      step();
      t++;
    end while (!rdy_seen && t < 40);
    in_valid = 1'b0;
    if (!rdy_seen) chk("accept_timeout", 128'(rdy_seen), 128'(1'b1));
    else model(c, c[ZW-1:0] ^ 12'hA5A, m, l, e, x, i45);
    is_45 = ~i45;   // mode changes after accept must not affect the running word
  endtask

  task automatic drain(input logic [3:0] pat);
    int i;
    i = 0;
    while (q.size() != 0 && i < 80) begin
      out_ready = pat[i[1:0]];
      step();
      i++;
    end
    out_ready = 1'b1;
    chk("drain_done", 128'(q.size() == 0), 128'(1'b1));
  endtask

  function automatic logic [CW-1:0] rnd_comb();
    logic [127:0] v;
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    return v[CW-1:0];
  endfunction

  initial begin
    logic [2:0] k;
    // reset state
    reset = 1'b1;
    step();
    step();
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_mux_sel", 128'(mux_sel), 128'(3'b000));
    chk("rst_mux_last", 128'(mux_last), 128'(1'b0));
    chk("rst_drop", 128'(drop_pulse), 128'(1'b0));
    reset = 1'b0;
    step();

    // five beats, last/ee only on sel=5
    send(rnd_comb(), 5'b11111, 1'b1, 1'b1, 1'b1, 1'b1);
    drain(4'b1111);

    // single drop-one beat followed immediately by another word
    send(rnd_comb(), 5'b11011, 1'b0, 1'b0, 1'b0, 1'b1);
    send(rnd_comb(), 5'b11111, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    chk("no_bubble", 128'(vld_seen), 128'(1'b1));
    drain(4'b1111);

    // two holes: plain drop, then drop with road end
    send(rnd_comb(), 5'b10011, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    send(rnd_comb(), 5'b10011, 1'b1, 1'b1, 1'b0, 1'b1);
    drain(4'b1111);

    // 5/5 mode with a missing layer drops
    send(rnd_comb(), 5'b11110, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drain(4'b1111);

    // downstream stalls during a five-beat walk
    send(rnd_comb(), 5'b11111, 1'b1, 1'b1, 1'b0, 1'b1);
    drain(4'b1001);

    // reset during the third beat
    send(rnd_comb(), 5'b11111, 1'b1, 1'b0, 1'b0, 1'b1);
    out_ready = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    q.delete();
    chk("abort_out_valid", 128'(out_valid), 128'(1'b0));
    chk("abort_mux_sel", 128'(mux_sel), 128'(3'b000));
    step();
    reset = 1'b0;
    step();
    send(rnd_comb(), 5'b11101, 1'b1, 1'b1, 1'b1, 1'b1);
    drain(4'b1111);

    // mixed words with random masks and backpressure
    for (int i = 0; i < 10; i++) begin
      k = 3'($urandom_range(0, 5));
      send(rnd_comb(), ~(5'b00001 << k) & 5'b11111, 1'($urandom()), 1'($urandom()),
           1'($urandom()), 1'($urandom()));
      if ((i % 3) == 0) drain(4'($urandom()) | 4'b0001);
    end
    drain(4'b1111);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout vectors=%0d miscompares=%0d", n_vec, n_err);
    $fatal(1);
  end

endmodule
